pipelined_cla_adder: RTL

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor for the datapath ALU.
- Generalises the 4-bit parallel-carry unit to WIDTH bits using 4-bit groups and a second-level group lookahead.
- Adds add/sub/carry-in modes, status flags, and a valid/ready handshake with backpressure.
- Sits between the operand-select logic and the ALU result mux.

---
 rtl/pipelined_cla_adder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 captures per-bit propagate/generate and per-group (4-bit) P/G.
// Stage 2 resolves group carries with a flattened second-level lookahead,
// expands them into bit carries inside each group, and registers the
// result with its status flags. A valid/ready chain provides backpressure.
module pipelined_cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NG = WIDTH / 4;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  // op encoding: 00 ADD, 01 SUB, 10 ADC, 11 SBB. op[0] selects inversion of b.
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [NG-1:0]    w_pg;
  logic [NG-1:0]    w_gg;

  logic             w_s1_adv;
  logic             w_s2_adv;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_p;
  logic [WIDTH-1:0] r_s1_g;
  logic [NG-1:0]    r_s1_pg;
  logic [NG-1:0]    r_s1_gg;
  logic             r_s1_c0;
  logic             r_s1_a_msb;
  logic             r_s1_bx_msb;

  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_bc;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic [NG-1:0]    w_g_top;
  logic             w_unused;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  // Ready chain: a stage may advance when the stage after it is empty or moving.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Operand preparation: subtraction is a + ~b + c0, with c0 = 1 for plain SUB.
  always_comb begin
    w_bx = op[0] ? ~b : b;
    w_c0 = op[1] ? cin : op[0];
  end

  assign w_p = a ^ w_bx;
  assign w_g = a & w_bx;

  // First-level group propagate/generate for each 4-bit group.
  always_comb begin
    w_pg = '0;
    w_gg = '0;
    for (int k = 0; k < NG; k++) begin
      w_pg[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

  // Stage 1 register; data only captures on an accepted beat so op/cin are
  // sampled exclusively at acceptance. The operands themselves are fully
  // represented by P/G plus the two sign bits needed for overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_p      <= '0;
      r_s1_g      <= '0;
      r_s1_pg     <= '0;
      r_s1_gg     <= '0;
      r_s1_c0     <= 1'b0;
      r_s1_a_msb  <= 1'b0;
      r_s1_bx_msb <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_p      <= w_p;
        r_s1_g      <= w_g;
        r_s1_pg     <= w_pg;
        r_s1_gg     <= w_gg;
        r_s1_c0     <= w_c0;
        r_s1_a_msb  <= a[WIDTH-1];
        r_s1_bx_msb <= w_bx[WIDTH-1];
      end
    end
  end

  // Second-level lookahead: every group carry is a flat sum of products of
  // group G/P terms and c0, so there is no carry ripple between groups.
  always_comb begin
    logic v_acc;
    logic v_pp;
    v_acc   = 1'b0;
    v_pp    = 1'b1;
    w_gc    = '0;
    w_gc[0] = r_s1_c0;
    for (int k = 0; k < NG; k++) begin
      v_acc = 1'b0;
      v_pp  = 1'b1;
      for (int j = k; j >= 0; j--) begin
        v_acc = v_acc | (v_pp & r_s1_gg[j]);
        v_pp  = v_pp & r_s1_pg[j];
      end
      w_gc[k+1] = v_acc | (v_pp & r_s1_c0);
    end
  end

  // In-group 4-bit lookahead from each group's carry-in.
  always_comb begin
    logic v_acc;
    logic v_pp;
    v_acc = 1'b0;
    v_pp  = 1'b1;
    w_bc  = '0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        v_acc = 1'b0;
        v_pp  = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          v_acc = v_acc | (v_pp & r_s1_g[4*k+j]);
          v_pp  = v_pp & r_s1_p[4*k+j];
        end
        w_bc[4*k+i] = v_acc | (v_pp & w_gc[k]);
      end
    end
  end

  // The top generate bit of each group is already folded into its group G.
  always_comb begin
    w_g_top = '0;
    for (int k = 0; k < NG; k++) begin
      w_g_top[k] = r_s1_g[4*k+3];
    end
  end
  assign w_unused = ^w_g_top;

  assign w_sum = r_s1_p ^ w_bc;
  assign w_ovf = (r_s1_a_msb == r_s1_bx_msb) && (w_sum[WIDTH-1] != r_s1_a_msb);

  // Stage 2 register; holds the presented result steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_gc[NG];
        r_ovf   <= w_ovf;
        r_zero  <= (w_sum == '0);
        r_neg   <= w_sum[WIDTH-1];
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign negative  = r_neg;

endmodule
